// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: stage count, slice bounds and mode encodings shared by the pipe_adder files
package pipe_adder_pkg;
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;
  function automatic int num_stages(input int width, input int bps);
    return (width + bps - 1) / bps;
  endfunction
  function automatic int slice_lo(input int k, input int width, input int bps);
    return (k * bps < width) ? k * bps : width - 1;
  endfunction
  function automatic int slice_hi(input int k, input int width, input int bps);
    return ((k + 1) * bps < width) ? (k + 1) * bps - 1 : width - 1;
  endfunction
endpackage

// File: rtl/pipe_adder_slice.sv
// pipe_adder_slice: combinational SLICE_W-bit ripple-carry adder; cm is the carry into the slice MSB
module pipe_adder_slice #(
  parameter int SLICE_W = 1
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co,
  output logic               cm
);
  logic [SLICE_W:0] c;
  always_comb begin
    c[0] = ci;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[SLICE_W];
    cm = c[SLICE_W-1];
  end
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple-carry adder/subtractor with a globally stalled valid/ready pipeline.
// Defining PIPE_ADDER_OVF_EN adds the registered signed-overflow output ovf.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int STAGES = num_stages(WIDTH, BITS_PER_STAGE);
  // Level 0 is the input register; level k+1 holds the result of slice k.
  logic             vld_q [STAGES+1];
  logic             vld_d [STAGES+1];
  logic             c_q   [STAGES+1];
  logic             c_d   [STAGES+1];
  logic [WIDTH-1:0] s_q   [STAGES+1];
  logic [WIDTH-1:0] s_d   [STAGES+1];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] slc_sum;
  logic [STAGES-1:0] slc_co;
  logic [STAGES-1:0] slc_cm;
  logic adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = slice_lo(k, WIDTH, BITS_PER_STAGE);
    localparam int HI = slice_hi(k, WIDTH, BITS_PER_STAGE);
    pipe_adder_slice #(.SLICE_W(HI - LO + 1)) u_slice (
      .a (a_q[k][HI:LO]),
      .b (b_q[k][HI:LO]),
      .ci(c_q[k]),
      .s (slc_sum[HI:LO]),
      .co(slc_co[k]),
      .cm(slc_cm[k])
    );
  end
  always_comb begin
    adv      = !vld_q[STAGES] || out_ready;
    vld_d[0] = in_valid;
    a_d[0]   = a;
    b_d[0]   = (sub == SUB) ? ~b : b;
    c_d[0]   = (sub == SUB) ? 1'b1 : cin;
    s_d[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k+1] = vld_q[k];
      c_d[k+1]   = slc_co[k];
      for (int i = 0; i < WIDTH; i++)
        s_d[k+1][i] = (i >= slice_lo(k, WIDTH, BITS_PER_STAGE) && i <= slice_hi(k, WIDTH, BITS_PER_STAGE))
                      ? slc_sum[i] : s_q[k][i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '{default: 1'b0};
      c_q   <= '{default: 1'b0};
      s_q   <= '{default: '0};
      a_q   <= '{default: '0};
      b_q   <= '{default: '0};
    end else if (adv) begin
      vld_q <= vld_d;
      c_q   <= c_d;
      s_q   <= s_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end
`ifdef PIPE_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = slc_cm[STAGES-1] ^ slc_co[STAGES-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (adv) ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES];
  assign sum       = s_q[STAGES];
  assign cout      = c_q[STAGES];
endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready stream interface. WIDTH-bit operands are split into slices of BITS_PER_STAGE bits. Each pipeline stage adds one slice and hands its carry to the next stage, so the clock period is bounded by a single slice. Sits in the datapath between operand-producing logic and result consumers, replacing fixed 8-bit pipelined adders.

## Interface
- WIDTH, 8: operand and sum width in bits (≥1).
- BITS_PER_STAGE, 1: bits added per pipeline stage (1..WIDTH). STAGES = ceil(WIDTH/BITS_PER_STAGE); the last slice may be narrower.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands this cycle.
- sub  input  1  0 = A+B+cin; 1 = A−B (cin ignored).
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in, add mode only.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry-out. In sub mode, 1 = no borrow.
- ovf  output  1  signed overflow (only with PIPE_ADDER_OVF_EN).

## Operation
- Transfer in: in_valid && in_ready at a rising edge.
- Transfer out: out_valid && out_ready at a rising edge.
- Sub mode: b is inverted and carry-in is forced to 1 at acceptance. Result is A + ~B + 1 mod 2^WIDTH.
- Stage k (0..STAGES−1) adds slice k of A and B' with the carry registered by stage k−1. Stage 0 uses the effective carry-in.
- Skew: slice k operands are delayed k cycles in operand registers so they meet their carry.
- Deskew: completed sum slices travel with the transaction, so the whole result emerges together.
- Each stage has a valid bit. Operands, carry and partial sum move one stage per advance.
- Global stall, no bubbles collapsed: advance = !out_valid || out_ready; in_ready = advance.
- When advance is 0, every pipeline register holds. in_valid while stalled is not accepted, and the upstream side must hold its data.
- Up to STAGES transactions are in flight, in order. Results are never dropped or duplicated.
- Arithmetic: {cout,sum} = A + B' + c0, exact in WIDTH+1 bits.

## Timing
- Reset (rst_n low, asynchronous): every stage valid bit is 0, so out_valid = 0. sum, cout and ovf are 0. in_ready = 1 once out_valid = 0.
- Reset asserted mid-operation discards all in-flight transactions. The first edge after deassertion may accept new data.
- Latency: accepted at edge T, result has out_valid = 1 after edge T+STAGES, provided there is no stall. Stalls add one cycle per stalled edge.
- Throughput: one transaction per cycle while out_ready = 1.
- Back-to-back pipeline: a result can leave and a new operand enter on the same edge.
- Hold rule: out_valid, sum, cout and ovf stay stable while out_valid && !out_ready.
- sub and cin are sampled only at acceptance, never later.

## Configuration
- PIPE_ADDER_OVF_EN defined:
  - The ovf port exists.
  - Stage STAGES−1 also registers its carry into the MSB, and ovf = carry_into_msb ^ cout. It is aligned with sum and 0 at reset.
- Not defined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package pipe_adder_pkg:
  - function num_stages(width, bps), giving ceil(width/bps).
  - function slice_lo/slice_hi(k, width, bps), giving bit bounds of slice k.
  - localparam ADD=1'b0, SUB=1'b1.
- Sub-module pipe_adder_slice:
  - Parametrised SLICE_W.
  - Combinational ripple of SLICE_W full adders, with carry-in, carry-out and MSB carry-in outputs.
  - Instantiated STAGES times by a generate loop.
  - The top level holds all registers, valid bits and the stall logic.

## Test plan
- WIDTH=8, BPS=1: a=0xFF, b=0x01, sub=0, cin=0 → after 8 cycles sum=0x00, cout=1.
- WIDTH=8, BPS=1: sub=1, a=0x05, b=0x07 → sum=0xFE, cout=0. Then a=0x07, b=0x05 → sum=0x02, cout=1.
- WIDTH=8, BPS=3 (STAGES=3): stream a=0..19, b=0..19, cin=1, out_ready=1 → sum=2i+1 on consecutive cycles starting 3 cycles after the first accept.
- Backpressure: out_ready toggled pseudo-randomly over 100 random transactions → in-order results matching a reference model. in_ready=0 exactly when out_valid && !out_ready. Outputs are stable while stalled.
- Reset: drive rst_n low with 3 transactions in flight → out_valid=0 immediately (asynchronous). No stale result appears after release.
- PIPE_ADDER_OVF_EN, WIDTH=8: 0x7F+0x01 → ovf=1. 0x80−0x01 → ovf=1. 0x10+0x20 → ovf=0.
